// File: rtl/bsg_inv_arb.sv
// Purpose: round-robin arbiter sharing one inverter among els_p requesters; registers ~data of the grantee.
// Latency: 1 cycle from yumi_o grant to v_o/data_o/id_o; sustains one result per cycle.
// Backpressure: no grant while the result register is FULL and yumi_i=0; results are held until taken.
//
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset
//   lock_i     - (only with BSG_INV_ARB_LOCK_EN) re-grant the last grantee while it keeps v_i set
//   v_i        - per-requester valid
//   data_i     - per-requester operand, requester k at [k*width_p +: width_p]
//   yumi_o     - one-hot grant, high in the cycle the operand is consumed
//   v_o        - result register holds a valid result
//   data_o     - bitwise inverse of the granted operand
//   id_o       - index of the requester that produced data_o
//   yumi_i     - consumer takes data_o this cycle (only meaningful while v_o=1)
//
// Optional feature macro: BSG_INV_ARB_LOCK_EN (adds lock_i).

module bsg_inv_arb #(
   parameter int width_p = 16,
   parameter int els_p   = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
`ifdef BSG_INV_ARB_LOCK_EN
   input  logic                     lock_i,
`endif
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic [els_p-1:0]         yumi_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   output logic [$clog2(els_p)-1:0] id_o,
   input  logic                     yumi_i
);

   localparam int id_w = $clog2(els_p);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e            state_r, state_n;
   logic [width_p-1:0] data_r;
   logic [id_w-1:0]   id_r;
   logic [id_w-1:0]   last_grant_r;
   // Goes high on the first edge after reset release, so that edge itself
   // never carries a grant.
   logic              run_r;

   logic              can_accept;
   logic              rr_found;
   logic [id_w-1:0]   rr_id;
   logic              sel_found;
   logic [id_w-1:0]   sel_id;
   logic              grant_v;
   logic [width_p-1:0] sel_data;
   int                scan_idx;
   logic [id_w-1:0]   scan_id;

   // Result register can take a new value when empty, or when full and the
   // current value is being consumed this cycle.
   assign can_accept = run_r && ((state_r == EMPTY) || yumi_i);

   // Round-robin: first valid requester scanning upward from last_grant+1.
   always_comb begin
      rr_found = 1'b0;
      rr_id    = '0;
      scan_idx = 0;
      scan_id  = '0;
      for (int i = 1; i <= els_p; i++) begin
         scan_idx = int'(last_grant_r) + i;
         if (scan_idx >= els_p) scan_idx = scan_idx - els_p;
         scan_id = id_w'(scan_idx);
         if (!rr_found && v_i[scan_id]) begin
            rr_found = 1'b1;
            rr_id    = scan_id;
         end
      end
   end

`ifdef BSG_INV_ARB_LOCK_EN
   // Lock overrides round-robin only while the previous grantee still requests.
   always_comb begin
      sel_found = rr_found;
      sel_id    = rr_id;
      if (lock_i && v_i[last_grant_r]) begin
         sel_found = 1'b1;
         sel_id    = last_grant_r;
      end
   end
`else
   assign sel_found = rr_found;
   assign sel_id    = rr_id;
`endif

   assign grant_v = can_accept && sel_found;

   always_comb begin
      yumi_o = '0;
      if (grant_v) yumi_o[sel_id] = 1'b1;
   end

   // Single shared inverter sits after the operand mux.
   assign sel_data = data_i[sel_id*width_p +: width_p];

   // Next-state: a grant always fills the register; otherwise a take empties it.
   always_comb begin
      state_n = state_r;
      case (state_r)
         EMPTY: if (grant_v) state_n = FULL;
         FULL: begin
            if (grant_v)     state_n = FULL;
            else if (yumi_i) state_n = EMPTY;
         end
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r      <= EMPTY;
         data_r       <= '0;
         id_r         <= '0;
         last_grant_r <= id_w'(els_p - 1);
         run_r        <= 1'b0;
      end else begin
         state_r <= state_n;
         run_r   <= 1'b1;
         if (grant_v) begin
            data_r       <= ~sel_data;
            id_r         <= sel_id;
            last_grant_r <= sel_id;
         end
      end
   end

   assign v_o    = (state_r == FULL);
   assign data_o = data_r;
   assign id_o   = id_r;

endmodule

// File: tb/tb_bsg_inv_arb.sv
// Purpose: self-checking bench for bsg_inv_arb with a queue-free behavioural model.
// Latency: model predicts yumi_o in the drive cycle and results one edge later.
// Backpressure: yumi_i is randomly withheld while the model says a result is present.

module tb_bsg_inv_arb;

   localparam int W = 16;
   localparam int N = 4;

   logic           clk_i = 1'b0;
   logic           reset_n_i;
   logic           lock_i;
   logic [N-1:0]   v_i;
   logic [N*W-1:0] data_i;
   logic [N-1:0]   yumi_o;
   logic           v_o;
   logic [W-1:0]   data_o;
   logic [1:0]     id_o;
   logic           yumi_i;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit        m_full;
   bit        m_run;
   bit [W-1:0] m_data;
   int        m_id;
   int        m_last;

   always #5 clk_i = ~clk_i;

   bsg_inv_arb #(.width_p(W), .els_p(N)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
`ifdef BSG_INV_ARB_LOCK_EN
      .lock_i    (lock_i),
`endif
      .v_i       (v_i),
      .data_i    (data_i),
      .yumi_o    (yumi_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .id_o      (id_o),
      .yumi_i    (yumi_i)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Who gets the grant by the spec's rules: lock first (if built), then the
   // first requester after the last grantee, wrapping modulo N; -1 if none.
   function automatic int m_pick(input logic [N-1:0] v, input logic lk);
      int c;
`ifdef BSG_INV_ARB_LOCK_EN
      if (lk && v[m_last]) return m_last;
`endif
      for (int k = 1; k <= N; k++) begin
         c = (m_last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_full = 0; m_run = 0; m_data = '0; m_id = 0; m_last = N - 1;
   endtask

   // Called at a negedge: drive, check against the model, advance one edge.
   task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic y, input logic lk, output logic [N-1:0] yo);
      int g;
      logic [N-1:0] exp_y;
      v_i = v; data_i = d; yumi_i = y & m_full; lock_i = lk;
      #1;
      g = (m_run && (!m_full || yumi_i)) ? m_pick(v, lk) : -1;
      exp_y = '0;
      if (g >= 0) exp_y[g] = 1'b1;
      yo = yumi_o;
      check("yumi_o", 32'(yumi_o), 32'(exp_y));
      check("v_o", 32'(v_o), 32'(m_full));
      check("data_o", 32'(data_o), 32'(m_data));
      check("id_o", 32'(id_o), 32'(m_id));
      @(posedge clk_i);
      m_run = 1;
      if (g >= 0) begin
         m_full = 1; m_data = ~d[g*W +: W]; m_id = g; m_last = g;
      end else if (m_full && yumi_i) begin
         m_full = 0;
      end
      @(negedge clk_i);
   endtask

   task automatic rand_steps(input int n);
      logic [N-1:0] yo;
      for (int i = 0; i < n; i++)
         step(N'($urandom_range(0, (1 << N) - 1)), {$urandom, $urandom},
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), yo);
   endtask

   logic [N-1:0]   yo;
   logic [N*W-1:0] dd;

   initial begin
      reset_n_i = 1'b0; v_i = '1; data_i = {$urandom, $urandom}; yumi_i = 1'b0; lock_i = 1'b0;
      m_reset();
      repeat (3) @(negedge clk_i);
      // reset state with all requesters active
      check("rst_yumi", 32'(yumi_o), 32'h0);
      check("rst_v", 32'(v_o), 32'h0);
      check("rst_data", 32'(data_o), 32'h0000);
      check("rst_id", 32'(id_o), 32'h0);
      reset_n_i = 1'b1;
      // release edge: nothing granted even though requests are pending
      step('1, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("rel_no_grant", 32'(yo), 32'h0);

      // fairness: 0,1,2,3,0 with everyone requesting and the consumer always ready
      for (int i = 0; i < 5; i++) begin
         step('1, {$urandom, $urandom}, 1'b1, 1'b0, yo);
         check("fair", 32'(yo), 32'(4'b0001 << (i % 4)));
      end

      // single requester 2 with operand 00FF
      dd = {$urandom, $urandom};
      dd[2*W +: W] = 16'h00FF;
      step(4'b0100, dd, 1'b1, 1'b0, yo);
      check("single_grant", 32'(yo), 32'h4);
      #1;
      check("single_v", 32'(v_o), 32'h1);
      check("single_data", 32'(data_o), 32'hFF00);
      check("single_id", 32'(id_o), 32'h2);

      // backpressure: held full for 5 cycles, nothing granted, result stable
      for (int i = 0; i < 5; i++) begin
         step(4'b0011, {$urandom, $urandom}, 1'b0, 1'b0, yo);
         check("bp_yumi", 32'(yo), 32'h0);
         check("bp_data", 32'(data_o), 32'hFF00);
      end
      step(4'b0011, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("bp_release", 32'(yo), 32'h1);

      // wrap: get last_grant to 3, then 1001 alternates 0,3,0
      step(4'b1000, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("wrap_pre", 32'(yo), 32'h8);
      step(4'b1001, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("wrap0", 32'(yo), 32'h1);
      step(4'b1001, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("wrap1", 32'(yo), 32'h8);
      step(4'b1001, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("wrap2", 32'(yo), 32'h1);

      // drain to empty: consumer takes, nobody requests
      step(4'b0000, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("drain_v", 32'(v_o), 32'h0);

`ifdef BSG_INV_ARB_LOCK_EN
      // lock: last grant 1, lock holds requester 1 until released
      step(4'b0010, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      for (int i = 0; i < 4; i++) begin
         step(4'b0011, {$urandom, $urandom}, 1'b1, 1'b1, yo);
         check("lock_hold", 32'(yo), 32'h2);
      end
      step(4'b0011, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("lock_release", 32'(yo), 32'h1);
`endif

      rand_steps(400);

      // reset in the middle of traffic discards the held result
      step(4'b0100, {$urandom, $urandom}, 1'b0, 1'b0, yo);
      reset_n_i = 1'b0;
      v_i = '1;
      #1;
      m_reset();
      check("midrst_v", 32'(v_o), 32'h0);
      check("midrst_data", 32'(data_o), 32'h0);
      check("midrst_yumi", 32'(yumi_o), 32'h0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      step(4'b0110, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      step(4'b0110, {$urandom, $urandom}, 1'b1, 1'b0, yo);
      check("midrst_first", 32'(yo), 32'h2);

      rand_steps(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard stop so the run cannot hang
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/bsg_inv_arb.md
BSG_INV_ARB -- requirements
Module: bsg_inv_arb

Interface
REQ-001 SHALL have parameter width_p, default 16, data width of each requester and of the shared inverter.
REQ-002 SHALL have parameter els_p, default 4, number of requesters (2..8).
REQ-003 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port v_i  input  els_p  per-requester valid.
REQ-006 SHALL have port data_i  input  els_p*width_p  per-requester operand, requester k in bits [k*width_p +: width_p].
REQ-007 SHALL have port yumi_o  output  els_p  one-hot grant, asserted in the cycle requester k's operand is consumed.
REQ-008 SHALL have port v_o  output  1  result register holds a valid result.
REQ-009 SHALL have port data_o  output  width_p  bitwise inverse of the granted operand.
REQ-010 SHALL have port id_o  output  clog2(els_p)  index of the requester that produced data_o.
REQ-011 SHALL have port yumi_i  input  1  consumer takes data_o this cycle; legal only while v_o=1.

Function
REQ-012 SHALL contain one shared width_p-bit inverter; data_o = ~(granted data_i), registered.
REQ-013 SHALL implement a two-state result FSM: EMPTY (v_o=0), FULL (v_o=1).
REQ-014 SHALL treat the result register as able to accept a new result when state=EMPTY, or state=FULL with yumi_i=1.
REQ-015 SHALL assert at most one yumi_o bit, and only when the register can accept and the grantee has v_i=1.
REQ-016 SHALL choose the grantee round-robin: the first requester with v_i=1 scanning upward from last_grant+1, wrapping at els_p-1 to 0.
REQ-017 SHALL update last_grant only in cycles where a yumi_o bit is asserted.
REQ-018 SHALL, in a grant cycle, load data_o and id_o at the next edge and set state FULL; latency is exactly 1 cycle from grant to v_o.
REQ-019 SHALL, on FULL with yumi_i=1 and any v_i set, grant and reload in the same cycle, giving 1 result per cycle sustained.
REQ-020 SHALL, on FULL with yumi_i=1 and no v_i set, go EMPTY with data_o and id_o held.
REQ-021 SHALL, on FULL with yumi_i=0, hold data_o, id_o, v_o and assert no yumi_o.
REQ-022 SHALL make yumi_o combinationally dependent on v_i, yumi_i and state only, never on data_i.
REQ-023 SHALL ignore yumi_i while EMPTY: no state change.

Reset
REQ-024 SHALL, while reset_n_i=0, force state=EMPTY, v_o=0, data_o=0, id_o=0, last_grant=els_p-1, and yumi_o=0.
REQ-025 SHALL discard any in-flight result when reset asserts mid-operation; first grant after release goes to the lowest-indexed active requester.
REQ-026 SHALL take reset release synchronously to clk_i; no grant in the release cycle's preceding edge.

Configuration
REQ-027 SHALL, when BSG_INV_ARB_LOCK_EN is defined, add input lock_i (1 bit): while lock_i=1 and the last grantee has v_i=1, that requester is re-granted regardless of round-robin order.
REQ-028 SHALL, without BSG_INV_ARB_LOCK_EN, omit lock_i and behave per REQ-016 only.

Verification
REQ-029 Reset: hold reset_n_i=0 with v_i=4'b1111 -> yumi_o=0, v_o=0, data_o=16'h0000, id_o=0.
REQ-030 Single: v_i=4'b0100, data_i[2]=16'h00FF, yumi_i=1 held -> yumi_o=4'b0100 in cycle 0, cycle 1 v_o=1, data_o=16'hFF00, id_o=2.
REQ-031 Fairness: v_i=4'b1111 held, yumi_i=1 held -> grants 0,1,2,3,0,... one per cycle, id_o tracks 1 cycle later.
REQ-032 Backpressure: FULL with yumi_i=0 for 5 cycles, v_i=4'b0011 -> yumi_o=0 throughout, data_o stable; first yumi_i=1 cycle grants next in order.
REQ-033 Wrap: last_grant=3, v_i=4'b1001 -> grant 0, then 3, then 0.
REQ-034 Lock (macro defined): lock_i=1, v_i=4'b0011, last grant 1 -> requester 1 granted every cycle until lock_i=0, then 0 granted.
